// File: rtl/main_design.sv
// Registered ALU: ADD/XOR/AND/OR with one-cycle latency and a one-cycle result strobe.
// Optional zero/carry flag outputs are built only when MAIN_DESIGN_FLAGS_EN is defined.
module main_design #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef MAIN_DESIGN_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry
`endif
);

    // in_valid is a strobe with no ready: every cycle it is high, the operands are
    // captured and out_valid pulses in the next cycle, so back-to-back inputs stream.
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
`ifdef MAIN_DESIGN_FLAGS_EN
    logic             carry_res;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
`endif

    always_comb begin
        result = '0;
`ifdef MAIN_DESIGN_FLAGS_EN
        carry_res = 1'b0;
`endif
        case (opcode)
            2'b00: begin
`ifdef MAIN_DESIGN_FLAGS_EN
                {carry_res, result} = {1'b0, a} + {1'b0, b};
`else
                result = a + b;
`endif
            end
            2'b01:   result = a ^ b;
            2'b10:   result = a & b;
            2'b11:   result = a | b;
            default: result = '0;
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
`ifdef MAIN_DESIGN_FLAGS_EN
        zero_d      = zero_q;
        carry_d     = carry_q;
`endif
        if (in_valid) begin
            out_d   = result;
`ifdef MAIN_DESIGN_FLAGS_EN
            zero_d  = (result == '0);
            carry_d = carry_res;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef MAIN_DESIGN_FLAGS_EN
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef MAIN_DESIGN_FLAGS_EN
            zero_q      <= zero_d;
            carry_q     <= carry_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef MAIN_DESIGN_FLAGS_EN
    assign zero      = zero_q;
    assign carry     = carry_q;
`endif

endmodule

// File: tb/tb_main_design.sv
// Self-checking bench for main_design: arithmetic model with an expected queue plus
// hand-computed directed vectors. Flag checks are active when MAIN_DESIGN_FLAGS_EN is defined.
module tb_main_design;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef MAIN_DESIGN_FLAGS_EN
    logic         zero;
    logic         carry;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // expected entries are {carry, zero, out}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp = '0;

    main_design #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
`ifdef MAIN_DESIGN_FLAGS_EN
        ,
        .zero      (zero),
        .carry     (carry)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // arithmetic model computed from the operation definitions
    function automatic logic [W+1:0] model(input logic [1:0] op, input int ua, input int ub);
        int r;
        bit c;
        c = 1'b0;
        case (op)
            2'd0: begin
                r = ua + ub;
                c = (r >= (1 << W));
                r = r % (1 << W);
            end
            2'd1: r = ua ^ ub;
            2'd2: r = ua & ub;
            default: r = ua | ub;
        endcase
        return {c, (r == 0), r[W-1:0]};
    endfunction

    always @(posedge clk) begin
        if (rst_n && in_valid)
            exp_q.push_back(model(opcode, int'(a), int'(b)));
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        last_exp = '0;
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (check_en) begin
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check("model_out_valid", {31'd0, out_valid}, 32'd1);
            end else begin
                check("model_out_valid", {31'd0, out_valid}, 32'd0);
            end
            check("model_out", {24'd0, out}, {24'd0, last_exp[W-1:0]});
`ifdef MAIN_DESIGN_FLAGS_EN
            check("model_zero",  {31'd0, zero},  {31'd0, last_exp[W]});
            check("model_carry", {31'd0, carry}, {31'd0, last_exp[W+1]});
`endif
        end
    end

    // driver tasks: inputs change on the falling edge
    task automatic send(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        opcode   = 2'b10;
        a        = 8'hA5;
        b        = 8'h5A;
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [W-1:0] eo, input logic ev,
                       input logic ez, input logic ec);
        check({name, "_out"}, {24'd0, out}, {24'd0, eo});
        check({name, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
`ifdef MAIN_DESIGN_FLAGS_EN
        check({name, "_zero"},  {31'd0, zero},  {31'd0, ez});
        check({name, "_carry"}, {31'd0, carry}, {31'd0, ec});
`else
        if (ez === 1'bx || ec === 1'bx) $display("note: flag literal is unknown in %s", name);
`endif
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        opcode   = 2'b00;
        a        = '0;
        b        = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        lit("post_reset_quiet", 8'h00, 1'b0, 1'b0, 1'b0);

        send(2'b01, 8'h00, 8'h00);
        lit("xor_zero", 8'h00, 1'b1, 1'b1, 1'b0);

        send(2'b01, 8'h01, 8'h00);
        lit("xor_seq0", 8'h01, 1'b1, 1'b0, 1'b0);
        send(2'b01, 8'h01, 8'h01);
        lit("xor_seq1", 8'h00, 1'b1, 1'b1, 1'b0);
        send(2'b01, 8'h1F, 8'h11);
        lit("xor_seq2", 8'h0E, 1'b1, 1'b0, 1'b0);

        send(2'b00, 8'hFF, 8'h01);
        lit("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
        send(2'b00, 8'h10, 8'h22);
        lit("add_plain", 8'h32, 1'b1, 1'b0, 1'b0);
        send(2'b00, 8'hFF, 8'hFF);
        lit("add_max", 8'hFE, 1'b1, 1'b0, 1'b1);

        send(2'b10, 8'hF0, 8'h3C);
        lit("and", 8'h30, 1'b1, 1'b0, 1'b0);
        send(2'b11, 8'hF0, 8'h3C);
        lit("or", 8'hFC, 1'b1, 1'b0, 1'b0);
        send(2'b10, 8'hAA, 8'h55);
        lit("and_zero", 8'h00, 1'b1, 1'b1, 1'b0);

        send(2'b01, 8'h1F, 8'h11);
        lit("hold_load", 8'h0E, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            lit("hold", 8'h0E, 1'b0, 1'b0, 1'b0);
        end

        // asynchronous reset in the middle of the low clock phase
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        send(2'b11, 8'hFF, 8'h0F);
        lit("capture_in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(1);
        lit("release_quiet", 8'h00, 1'b0, 1'b0, 1'b0);

        send(2'b00, 8'h7F, 8'h01);
        lit("after_reset_add", 8'h80, 1'b1, 1'b0, 1'b0);
        idle(2);
        lit("final_hold", 8'h80, 1'b0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
